axi_4_lite_regfile_slv: RTL and testbench
=========================================

Name: axi_4_lite_regfile_slv

Overview:
Parametrised AXI4-Lite slave register file, the successor to the fixed-size slave. It is generic in data width, register count and byte-address width. It adds:
- full independent AW/W/B and AR/R handshaking with AW/W buffering
- byte-strobe writes
- per-register read-only protection
- SLVERR responses for illegal accesses
- a flat register-contents output for fabric logic

Parameters:
DATA_WIDTH, 32, AXI data width in bits; 32 or 64.
NUM_REGS, 8, number of registers; 1..256.
ADDR_WIDTH, 5, AXI byte-address width; must be >= ADDR_LSB + clog2(NUM_REGS).
RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only from AXI.
RESET_VALUE, 0, value loaded into every register on reset.

Ports:
S_AXI_ACLK  in  1  clock; all logic on rising edge.
S_AXI_ARESET  in  1  synchronous, active-high reset.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_AWADDR  in  ADDR_WIDTH  write byte address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_WDATA  in  DATA_WIDTH  write data.
S_AXI_WSTRB  in  DATA_WIDTH/8  byte-lane enables.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_ARADDR  in  ADDR_WIDTH  read byte address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
S_AXI_RDATA  out  DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
regs_o  out  NUM_REGS*DATA_WIDTH  register i on bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
Reset:
- S_AXI_ARESET=1 at an edge applies regardless of any transfer in flight.
- All registers load RESET_VALUE; AW/W buffers are emptied; BVALID=0, RVALID=0.
- BRESP=0, RRESP=0, RDATA=0. AWREADY, WREADY and ARREADY read 1 from the first cycle after reset.

Addressing:
- ADDR_LSB = clog2(DATA_WIDTH/8). Register index = addr[ADDR_WIDTH-1:ADDR_LSB]; low bits are ignored, so unaligned addresses round down.
- An index >= NUM_REGS is out of range.

Write channel:
- AW and W are independent one-entry buffers (aw_full, w_full). AWREADY = !aw_full; WREADY = !w_full. Either may arrive first, or both in the same cycle.
- Commit condition: aw_full && w_full && (!BVALID || BREADY).
- On the commit edge:
  - Register updated per byte lane where WSTRB=1.
  - BVALID set and BRESP loaded.
  - Both buffers cleared.
- Minimum latency: AW+W handshake at edge N -> commit and BVALID=1 after edge N+1.
- Error writes: index out of range or RO_MASK bit set -> no register change, BRESP=SLVERR. WSTRB=0 on a legal register -> OKAY with no change.
- BVALID/BRESP are held stable until BREADY. A commit that coincides with BVALID&&BREADY keeps BVALID=1 carrying the new response (back-to-back).
- While buffers are full and B is stalled, AWREADY/WREADY stay low (backpressure).

Read channel:
- ARREADY = !RVALID || RREADY.
- AR handshake at edge N -> RVALID=1, RDATA and RRESP registered at that edge (latency 1).
- Out-of-range read -> RDATA=0, RRESP=SLVERR. A read of an RO register is OKAY.
- RDATA/RRESP are held until RREADY. With RREADY held high, one read completes per cycle.

Simultaneous events:
- Read of a register committed on the same edge returns the pre-write value.
- Read and write channels never block each other.

regs_o: continuously reflects register contents; RO registers stay at RESET_VALUE.

Test Plan:
1. Reset, then AW=0x04 and W=0xDEADBEEF (WSTRB=4'hF) in the same cycle, BREADY=1 -> BVALID one cycle later with BRESP=00; read 0x04 -> RDATA=0xDEADBEEF, RRESP=00, RVALID one edge after the AR handshake.
2. W issued 3 cycles before AW (addr 0x08, data 0x11223344, WSTRB=4'b0101) over a register holding 0xFFFFFFFF -> register = 0xFF22FF44; regs_o[95:64] matches.
3. RO_MASK=8'h80: write 0x1C with 0x12345678 -> BRESP=SLVERR, register stays 0; read 0x1C -> RRESP=OKAY, RDATA=0. With ADDR_WIDTH=6, write 0x20 -> SLVERR and read 0x20 -> RDATA=0, RRESP=SLVERR.
4. BREADY=0 for 5 cycles with a second AW/W pending -> BVALID/BRESP stable, AWREADY=WREADY=0 after the second accept. Then BREADY=1 -> second response follows on the next edge and both writes land.
5. RREADY held 1 with 4 back-to-back ARs (0x00, 0x04, 0x08, 0x0C) -> 4 consecutive RVALID cycles with matching data. Same-edge write to 0x00 with 0xA5A5A5A5 while reading 0x00 -> old value returned.
6. Assert S_AXI_ARESET while BVALID=1 and aw_full=1 -> next cycle BVALID=0, RVALID=0, all regs_o=RESET_VALUE, buffered write discarded.

Source files
------------

// File: rtl/axi_4_lite_regfile_slv.sv
// AXI4-Lite slave register file: independent AW/W buffering, byte-strobe
// writes, per-register read-only protection, SLVERR for illegal accesses,
// and a flat view of all registers for fabric logic.

// One register: reset value on reset, byte-lane update when written.
module axi_4_lite_regfile_slv_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   q
);
  // Byte-masked storage
  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VALUE;
    else if (we)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
  end
endmodule

module axi_4_lite_regfile_slv #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESET,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  output logic [1:0]                     S_AXI_BRESP,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int STRB_W   = DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                aw_full, w_full;
  logic [IDX_W-1:0]    aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0] aw_hit, ar_hit;
  logic [IDX_W-1:0]    ar_idx;
  logic                aw_in_range, ar_in_range, aw_err, commit;
  logic [DATA_WIDTH-1:0] rd_data;

  // Protocol and sub-word address bits carry no meaning for this block.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign ar_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign aw_in_range = int'(aw_idx_q) < NUM_REGS;
  assign ar_in_range = int'(ar_idx) < NUM_REGS;
  // Illegal write: index past the file, or a read-only target.
  assign aw_err      = !aw_in_range || |(aw_hit & RO_MASK);
  // Both halves buffered and the B slot free (or draining this edge).
  assign commit      = aw_full && w_full && (!S_AXI_BVALID || S_AXI_BREADY);

  assign S_AXI_AWREADY = !aw_full;
  assign S_AXI_WREADY  = !w_full;
  assign S_AXI_ARREADY = !S_AXI_RVALID || S_AXI_RREADY;
  assign regs_o        = regs_q;

  // Per-register storage; RO registers never see a write enable.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign aw_hit[i] = aw_idx_q == IDX_W'(i);
    assign ar_hit[i] = ar_idx == IDX_W'(i);
    axi_4_lite_regfile_slv_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_reg (
      .clk  (S_AXI_ACLK),
      .rst  (S_AXI_ARESET),
      .we   (commit && aw_hit[i] && !RO_MASK[i]),
      .strb (wstrb_q),
      .wdata(wdata_q),
      .q    (regs_q[i])
    );
  end

  // Read mux; yields zero when no register matches (out of range).
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_hit[i]) rd_data = regs_q[i];
  end

  // AW/W one-entry buffers; both drain together on commit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (S_AXI_AWVALID && !aw_full) begin
        aw_full  <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (S_AXI_WVALID && !w_full) begin
        w_full  <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Write response: a commit reloads B even while the old one drains.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else if (commit) begin
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= aw_err ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_BREADY) begin
      S_AXI_BVALID <= 1'b0;
    end
  end

  // Read response: registered one edge after the AR handshake.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= ar_in_range ? rd_data : '0;
      S_AXI_RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_4_lite_regfile_slv.sv
// Randomized self-checking bench for axi_4_lite_regfile_slv against an
// array-based model of the register file.
module tb_axi_4_lite_regfile_slv;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 6;
  localparam logic [NR-1:0] RO = 8'h80;

  logic clk = 0, rst = 1;
  logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
  logic S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
  logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0] S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic [DW-1:0] S_AXI_WDATA = '0;
  logic [DW/8-1:0] S_AXI_WSTRB = '0;
  logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [DW-1:0] S_AXI_RDATA;
  logic [NR*DW-1:0] regs_o;

  int n_chk = 0, n_err = 0;
  logic [DW-1:0] mdl [NR];

  always #5 clk = ~clk;

  axi_4_lite_regfile_slv #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
                           .RO_MASK(RO), .RESET_VALUE('0)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .regs_o(regs_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Model: register index is the byte address divided by the word size.
  function automatic logic [1:0] mdl_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                           input logic [DW/8-1:0] s);
    int idx = int'(a) / (DW/8);
    if (idx >= NR || RO[idx]) return 2'b10;
    for (int b = 0; b < DW/8; b++)
      if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  task automatic mdl_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
    int idx = int'(a) / (DW/8);
    if (idx >= NR) begin d = '0; r = 2'b10; end
    else begin d = mdl[idx]; r = 2'b00; end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NR; i++) chk(tag, regs_o[i*DW +: DW], mdl[i]);
  endtask

  // All drivers start and end at posedge+1.
  task automatic send_aw(input logic [AW-1:0] a, input int dly);
    bit done = 0;
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_AWVALID = 1; S_AXI_AWADDR = a;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk); done = S_AXI_AWREADY;
      @(posedge clk); #1;
    end
    S_AXI_AWVALID = 0;
    if (!done) chk("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input int dly);
    bit done = 0;
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_WVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk); done = S_AXI_WREADY;
      @(posedge clk); #1;
    end
    S_AXI_WVALID = 0;
    if (!done) chk("w_timeout", 0, 1);
  endtask

  task automatic wait_b(input logic [1:0] exp, input int dly, input string tag);
    bit done = 0;
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_BREADY = 1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (S_AXI_BVALID) begin chk({tag, "_bresp"}, S_AXI_BRESP, exp); done = 1; end
      @(posedge clk); #1;
    end
    S_AXI_BREADY = 0;
    if (!done) chk({tag, "_btimeout"}, 0, 1);
  endtask

  // lead > 0: W goes first by lead cycles; lead < 0: AW goes first.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                    input int lead, input int bdly, input string tag);
    logic [1:0] er;
    er = mdl_write(a, d, s);
    fork
      send_aw(a, lead > 0 ? lead : 0);
      send_w(d, s, lead < 0 ? -lead : 0);
    join
    wait_b(er, bdly, tag);
  endtask

  task automatic rd(input logic [AW-1:0] a, input int rdly, input string tag);
    logic [DW-1:0] ed; logic [1:0] er; bit done = 0;
    mdl_read(a, ed, er);
    S_AXI_ARVALID = 1; S_AXI_ARADDR = a;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk); done = S_AXI_ARREADY;
      @(posedge clk); #1;
    end
    S_AXI_ARVALID = 0;
    if (!done) chk({tag, "_artimeout"}, 0, 1);
    repeat (rdly) begin
      @(negedge clk); chk({tag, "_rvalid_hold"}, S_AXI_RVALID, 1);
      @(posedge clk); #1;
    end
    S_AXI_RREADY = 1;
    @(negedge clk);
    chk({tag, "_rvalid"}, S_AXI_RVALID, 1);
    chk({tag, "_rdata"}, S_AXI_RDATA, ed);
    chk({tag, "_rresp"}, S_AXI_RRESP, er);
    @(posedge clk); #1;
    S_AXI_RREADY = 0;
    @(negedge clk); chk({tag, "_rvalid_clr"}, S_AXI_RVALID, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] old, ed; logic [1:0] er; logic [1:0] e1, e2;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_bvalid", S_AXI_BVALID, 0); chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_bresp", S_AXI_BRESP, 0);   chk("rst_rresp", S_AXI_RRESP, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_rdy", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    chk_regs("rst_regs");
    @(posedge clk); #1;

    // 1: same-cycle AW+W, check B latency, read back
    e1 = mdl_write(6'h04, 32'hDEADBEEF, 4'hF);
    S_AXI_AWVALID = 1; S_AXI_AWADDR = 6'h04; S_AXI_WVALID = 1;
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_BREADY = 1;
    @(negedge clk); chk("t1_aw_w_rdy", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    @(posedge clk); #1; S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    @(negedge clk); chk("t1_bvalid_early", S_AXI_BVALID, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("t1_bvalid", S_AXI_BVALID, 1); chk("t1_bresp", S_AXI_BRESP, e1);
    @(posedge clk); #1; S_AXI_BREADY = 0;
    rd(6'h04, 0, "t1_rd");
    chk("t1_const", regs_o[63:32], 32'hDEADBEEF);

    // 2: W three cycles before AW, partial strobe
    wr(6'h08, 32'hFFFFFFFF, 4'hF, 0, 0, "t2_fill");
    wr(6'h08, 32'h11223344, 4'b0101, 3, 0, "t2_strb");
    chk("t2_const", regs_o[95:64], 32'hFF22FF44);
    chk_regs("t2_regs");

    // 3: read-only and out-of-range
    wr(6'h1C, 32'h12345678, 4'hF, 0, 0, "t3_ro");
    rd(6'h1C, 0, "t3_ro_rd");
    wr(6'h20, 32'h0BADF00D, 4'hF, -1, 0, "t3_oor");
    rd(6'h20, 1, "t3_oor_rd");
    chk("t3_ro_const", regs_o[255:224], 0);

    // 4: B stalled with a second write buffered behind it
    e1 = mdl_write(6'h1C, 32'hCAFE0001, 4'hF);
    fork send_aw(6'h1C, 0); send_w(32'hCAFE0001, 4'hF, 0); join
    e2 = mdl_write(6'h0C, 32'h0C0C0C0C, 4'hF);
    fork send_aw(6'h0C, 0); send_w(32'h0C0C0C0C, 4'hF, 0); join
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_bvalid_hold", S_AXI_BVALID, 1); chk("t4_bresp_hold", S_AXI_BRESP, e1);
      chk("t4_backpressure", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
      @(posedge clk); #1;
    end
    S_AXI_BREADY = 1;
    @(negedge clk); chk("t4_b1", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, e1});
    @(posedge clk); #1;
    @(negedge clk); chk("t4_b2", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, e2});
    @(posedge clk); #1; S_AXI_BREADY = 0;
    @(negedge clk); chk("t4_bdone", S_AXI_BVALID, 0);
    @(posedge clk); #1;
    chk_regs("t4_regs");

    // 5: back-to-back reads, then same-edge write/read of reg 0
    wr(6'h00, 32'h01234567, 4'hF, 0, 0, "t5_seed");
    S_AXI_RREADY = 1; S_AXI_ARVALID = 1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) S_AXI_ARADDR = AW'(4*k); else S_AXI_ARVALID = 0;
      @(negedge clk);
      if (k > 0) begin
        mdl_read(AW'(4*(k-1)), ed, er);
        chk("t5_b2b_rvalid", S_AXI_RVALID, 1);
        chk("t5_b2b_rdata", S_AXI_RDATA, ed);
      end
      if (k < 4) chk("t5_b2b_arready", S_AXI_ARREADY, 1);
      @(posedge clk); #1;
    end
    S_AXI_RREADY = 0;
    old = mdl[0];
    S_AXI_AWVALID = 1; S_AXI_AWADDR = 6'h00; S_AXI_WVALID = 1;
    S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_BREADY = 1;
    @(negedge clk); chk("t5_same_awrdy", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    S_AXI_ARVALID = 1; S_AXI_ARADDR = 6'h00; S_AXI_RREADY = 1;
    @(negedge clk); chk("t5_same_arrdy", S_AXI_ARREADY, 1);
    @(posedge clk); #1; S_AXI_ARVALID = 0;
    @(negedge clk);
    chk("t5_same_old", S_AXI_RDATA, old);
    chk("t5_same_b", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
    @(posedge clk); #1; S_AXI_RREADY = 0; S_AXI_BREADY = 0;
    e1 = mdl_write(6'h00, 32'hA5A5A5A5, 4'hF);
    rd(6'h00, 0, "t5_new");

    // 6: reset with B pending, AW buffered, R pending
    fork send_aw(6'h0C, 0); send_w(32'h55555555, 4'hF, 0); join
    send_aw(6'h10, 0);
    S_AXI_ARVALID = 1; S_AXI_ARADDR = 6'h04;
    @(posedge clk); #1; S_AXI_ARVALID = 0;
    @(negedge clk);
    chk("t6_pre", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY}, 3'b110);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    mdl_reset();
    @(negedge clk);
    chk("t6_bvalid", S_AXI_BVALID, 0); chk("t6_rvalid", S_AXI_RVALID, 0);
    chk("t6_rdy", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    chk_regs("t6_regs");
    @(posedge clk); #1;
    send_w(32'h000000FF, 4'hF, 0);
    repeat (3) begin
      @(negedge clk); chk("t6_no_commit", S_AXI_BVALID, 0);
      @(posedge clk); #1;
    end
    e1 = mdl_write(6'h14, 32'h000000FF, 4'hF);
    send_aw(6'h14, 0);
    wait_b(e1, 0, "t6_after");
    chk_regs("t6_after_regs");

    // Randomized mix of writes and reads
    for (int it = 0; it < 80; it++) begin
      logic [AW-1:0] a; int lead, dly;
      a = AW'($urandom_range(0, 2**AW-1));
      lead = int'($urandom_range(0, 6)) - 3;
      dly = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1)
        wr(a, $urandom, 4'($urandom_range(0, 15)), lead, dly, "rnd_wr");
      else
        rd(a, dly, "rnd_rd");
    end
    chk_regs("final_regs");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
